// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions for the fetch/decode front end.
//   ADDR_WIDTH/DATA_WIDTH : 12-bit address and data words
//   pdp_mem_opcode_s      : one-hot memory-reference decode + effective address
//   pdp_op7_opcode_s      : one-hot group-1/group-2 operate decode
//   ifd_state_e           : fetch/decode FSM states
//   OP7_*                 : recognised operate words (octal)
package pdp8_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 12;

  typedef struct packed {
    logic                  AND;
    logic                  TAD;
    logic                  ISZ;
    logic                  DCA;
    logic                  JMS;
    logic                  JMP;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;

  typedef enum logic [2:0] {
    FETCH,
    LOAD,
    IND_RD,
    IND_LOAD,
    IND_WR,
    ISSUE,
    WAIT,
    HALTED
  } ifd_state_e;

  localparam logic [DATA_WIDTH-1:0] OP7_NOP     = 12'o7000;
  localparam logic [DATA_WIDTH-1:0] OP7_IAC     = 12'o7001;
  localparam logic [DATA_WIDTH-1:0] OP7_RAL     = 12'o7004;
  localparam logic [DATA_WIDTH-1:0] OP7_RTL     = 12'o7006;
  localparam logic [DATA_WIDTH-1:0] OP7_RAR     = 12'o7010;
  localparam logic [DATA_WIDTH-1:0] OP7_RTR     = 12'o7012;
  localparam logic [DATA_WIDTH-1:0] OP7_CML     = 12'o7020;
  localparam logic [DATA_WIDTH-1:0] OP7_CMA     = 12'o7040;
  localparam logic [DATA_WIDTH-1:0] OP7_CIA     = 12'o7041;
  localparam logic [DATA_WIDTH-1:0] OP7_CLL     = 12'o7100;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA1    = 12'o7200;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA_CLL = 12'o7300;
  localparam logic [DATA_WIDTH-1:0] OP7_HLT     = 12'o7402;
  localparam logic [DATA_WIDTH-1:0] OP7_OSR     = 12'o7404;
  localparam logic [DATA_WIDTH-1:0] OP7_SKP     = 12'o7410;
  localparam logic [DATA_WIDTH-1:0] OP7_SNL     = 12'o7420;
  localparam logic [DATA_WIDTH-1:0] OP7_SZL     = 12'o7430;
  localparam logic [DATA_WIDTH-1:0] OP7_SZA     = 12'o7440;
  localparam logic [DATA_WIDTH-1:0] OP7_SNA     = 12'o7450;
  localparam logic [DATA_WIDTH-1:0] OP7_SMA     = 12'o7500;
  localparam logic [DATA_WIDTH-1:0] OP7_SPA     = 12'o7510;
  localparam logic [DATA_WIDTH-1:0] OP7_CLA2    = 12'o7600;

endpackage

// File: rtl/op7_decoder.sv
// Combinational decode of operate (opcode 7) words.
//   ir      : instruction word
//   op7     : one-hot operate decode (NOP substituted for undecodable words)
//   illegal : set for unrecognised opcode-7 words and all opcode-6 (IOT) words
module op7_decoder
  import pdp8_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] ir,
  output pdp_op7_opcode_s       op7,
  output logic                  illegal
);

  always_comb begin
    op7     = '0;
    illegal = 1'b0;
    if (ir[11:9] == 3'o7) begin
      case (ir)
        OP7_NOP:     op7.NOP     = 1'b1;
        OP7_IAC:     op7.IAC     = 1'b1;
        OP7_RAL:     op7.RAL     = 1'b1;
        OP7_RTL:     op7.RTL     = 1'b1;
        OP7_RAR:     op7.RAR     = 1'b1;
        OP7_RTR:     op7.RTR     = 1'b1;
        OP7_CML:     op7.CML     = 1'b1;
        OP7_CMA:     op7.CMA     = 1'b1;
        OP7_CIA:     op7.CIA     = 1'b1;
        OP7_CLL:     op7.CLL     = 1'b1;
        OP7_CLA1:    op7.CLA1    = 1'b1;
        OP7_CLA_CLL: op7.CLA_CLL = 1'b1;
        OP7_HLT:     op7.HLT     = 1'b1;
        OP7_OSR:     op7.OSR     = 1'b1;
        OP7_SKP:     op7.SKP     = 1'b1;
        OP7_SNL:     op7.SNL     = 1'b1;
        OP7_SZL:     op7.SZL     = 1'b1;
        OP7_SZA:     op7.SZA     = 1'b1;
        OP7_SNA:     op7.SNA     = 1'b1;
        OP7_SMA:     op7.SMA     = 1'b1;
        OP7_SPA:     op7.SPA     = 1'b1;
        OP7_CLA2:    op7.CLA2    = 1'b1;
        default: begin
          op7.NOP = 1'b1;
          illegal = 1'b1;
        end
      endcase
    end else if (ir[11:9] == 3'o6) begin
      op7.NOP = 1'b1;
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// PDP-8 instruction fetch and decode unit.
//   clk, reset_n        : clock, synchronous active-low reset
//   base_addr           : constant START_ADDR for the execution unit
//   pdp_mem_opcode      : memory-reference decode + effective address (ISSUE only)
//   pdp_op7_opcode      : operate decode (ISSUE only)
//   illegal_instr       : one-cycle pulse on an undecodable word
//   stall, PC_value     : execution-unit busy flag and program counter
//   ifu_rd_*/ifu_wr_*   : memory read (data one cycle after request) and write ports
module instr_fetch_decode
  import pdp8_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  illegal_instr,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_wr_req,
  output logic [ADDR_WIDTH-1:0] ifu_wr_addr,
  output logic [DATA_WIDTH-1:0] ifu_wr_data
);

  ifd_state_e            state_q, state_d;
  logic                  first_q, first_d;
  logic [4:0]            pc_page_q, pc_page_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;
  logic [DATA_WIDTH-1:0] ptr_q, ptr_d;

  pdp_op7_opcode_s       dec_op7;
  logic                  dec_illegal;
  logic [ADDR_WIDTH-1:0] load_ea;
  logic                  auto_idx;

  assign base_addr = START_ADDR;

  op7_decoder u_op7_decoder (
    .ir      (ir_q),
    .op7     (dec_op7),
    .illegal (dec_illegal)
  );

  // EA is formed from the word arriving in LOAD, so indirection can start next cycle.
  assign load_ea  = ifu_rd_data[7] ? {pc_page_q, ifu_rd_data[6:0]}
                                   : {5'b0, ifu_rd_data[6:0]};
  assign auto_idx = (ea_q[ADDR_WIDTH-1:3] == 9'o001);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      first_q   <= 1'b1;
      pc_page_q <= '0;
      ir_q      <= '0;
      ea_q      <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      pc_page_q <= pc_page_d;
      ir_q      <= ir_d;
      ea_q      <= ea_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    first_d        = first_q;
    pc_page_d      = pc_page_q;
    ir_d           = ir_q;
    ea_d           = ea_q;
    ptr_d          = ptr_q;
    ifu_rd_req     = 1'b0;
    ifu_rd_addr    = '0;
    ifu_wr_req     = 1'b0;
    ifu_wr_addr    = '0;
    ifu_wr_data    = '0;
    pdp_mem_opcode = '0;
    pdp_op7_opcode = '0;
    illegal_instr  = 1'b0;

    case (state_q)
      FETCH: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = first_q ? START_ADDR : PC_value;
        pc_page_d   = ifu_rd_addr[ADDR_WIDTH-1:7];
        first_d     = 1'b0;
        state_d     = LOAD;
      end
      LOAD: begin
        ir_d    = ifu_rd_data;
        ea_d    = load_ea;
        state_d = ((ifu_rd_data[11:9] <= 3'o5) && ifu_rd_data[8]) ? IND_RD : ISSUE;
      end
      IND_RD: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = ea_q;
        state_d     = IND_LOAD;
      end
      IND_LOAD: begin
        if (auto_idx) begin
          ptr_d   = ifu_rd_data + 12'd1;
          state_d = IND_WR;
        end else begin
          ptr_d   = ifu_rd_data;
          state_d = ISSUE;
        end
      end
      IND_WR: begin
        ifu_wr_req  = 1'b1;
        ifu_wr_addr = ea_q;
        ifu_wr_data = ptr_q;
        state_d     = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
        if (ir_q[11:9] <= 3'o5) begin
          case (ir_q[11:9])
            3'o0:    pdp_mem_opcode.AND = 1'b1;
            3'o1:    pdp_mem_opcode.TAD = 1'b1;
            3'o2:    pdp_mem_opcode.ISZ = 1'b1;
            3'o3:    pdp_mem_opcode.DCA = 1'b1;
            3'o4:    pdp_mem_opcode.JMS = 1'b1;
            default: pdp_mem_opcode.JMP = 1'b1;
          endcase
          pdp_mem_opcode.mem_inst_addr = ir_q[8] ? ptr_q : ea_q;
        end else begin
          pdp_op7_opcode = dec_op7;
          illegal_instr  = dec_illegal;
          if (dec_op7.HLT) state_d = HALTED;
        end
      end
      WAIT: begin
        if (!stall) state_d = FETCH;
      end
      HALTED: state_d = HALTED;
      default: state_d = FETCH;
    endcase

    // Outputs are forced quiet during reset so an in-flight write cannot complete.
    if (!reset_n) begin
      ifu_rd_req     = 1'b0;
      ifu_rd_addr    = '0;
      ifu_wr_req     = 1'b0;
      ifu_wr_addr    = '0;
      ifu_wr_data    = '0;
      pdp_mem_opcode = '0;
      pdp_op7_opcode = '0;
      illegal_instr  = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;
  import pdp8_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  stall = 1'b0;
  logic [ADDR_WIDTH-1:0] PC_value = '0;
  logic [ADDR_WIDTH-1:0] base_addr;
  pdp_mem_opcode_s       pdp_mem_opcode;
  pdp_op7_opcode_s       pdp_op7_opcode;
  logic                  illegal_instr;
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  ifu_wr_req;
  logic [ADDR_WIDTH-1:0] ifu_wr_addr;
  logic [DATA_WIDTH-1:0] ifu_wr_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_decode #(.START_ADDR(12'o0200)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .base_addr      (base_addr),
    .pdp_mem_opcode (pdp_mem_opcode),
    .pdp_op7_opcode (pdp_op7_opcode),
    .illegal_instr  (illegal_instr),
    .stall          (stall),
    .PC_value       (PC_value),
    .ifu_rd_req     (ifu_rd_req),
    .ifu_rd_addr    (ifu_rd_addr),
    .ifu_rd_data    (ifu_rd_data),
    .ifu_wr_req     (ifu_wr_req),
    .ifu_wr_addr    (ifu_wr_addr),
    .ifu_wr_data    (ifu_wr_data)
  );

  // Memory: reads return data the cycle after the request; writes are applied
  // by the checking code when it observes ifu_wr_req.
  logic [11:0] mem [4096];
  always @(posedge clk) if (ifu_rd_req) ifu_rd_data <= mem[ifu_rd_addr];

  // Recognised operate words, listed in the same order as the decode fields.
  logic [11:0] op7_words [22] = '{
    12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012, 12'o7020, 12'o7040,
    12'o7041, 12'o7100, 12'o7200, 12'o7300, 12'o7402, 12'o7404, 12'o7410, 12'o7420,
    12'o7430, 12'o7440, 12'o7450, 12'o7500, 12'o7510, 12'o7600};

  typedef struct {
    int              lat;
    pdp_mem_opcode_s m;
    pdp_op7_opcode_s o;
    bit              ill;
    bit              ind;
    bit              wr;
    bit              halt;
    logic [11:0]     ea;
    logic [11:0]     wdata;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0o%0o expected 0o%0o", tag, got, exp);
    end
  endtask

  // Instruction-level reference: what one instruction at pc must produce.
  function automatic exp_t model(input logic [11:0] pc);
    exp_t        e;
    logic [11:0] w, ptr;
    int          op;
    w       = mem[pc];
    op      = int'(w[11:9]);
    e.ea    = w[7] ? {pc[11:7], w[6:0]} : {5'b0, w[6:0]};
    e.ind   = (op <= 5) && w[8];
    e.wr    = e.ind && (e.ea >= 12'o10) && (e.ea <= 12'o17);
    ptr     = mem[e.ea];
    e.wdata = ptr + 12'd1;
    e.lat   = e.wr ? 5 : (e.ind ? 4 : 2);
    e.m     = '0;
    e.o     = '0;
    e.ill   = 1'b0;
    e.halt  = 1'b0;
    if (op <= 5) begin
      case (op)
        0: e.m.AND = 1'b1;
        1: e.m.TAD = 1'b1;
        2: e.m.ISZ = 1'b1;
        3: e.m.DCA = 1'b1;
        4: e.m.JMS = 1'b1;
        default: e.m.JMP = 1'b1;
      endcase
      e.m.mem_inst_addr = e.wr ? e.wdata : (e.ind ? ptr : e.ea);
    end else begin
      e.ill = 1'b1;
      for (int k = 0; k < 22; k++)
        if (w == op7_words[k]) begin
          e.o   = pdp_op7_opcode_s'(22'h200000 >> k);
          e.ill = 1'b0;
        end
      if (e.ill) e.o.NOP = 1'b1;
      e.halt = (w == 12'o7402);
    end
    return e;
  endfunction

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      reset_n  = 1'b0;
      stall    = 1'($urandom);
      PC_value = 12'($urandom);
      #1;
      check("rst_rd_req",  32'(ifu_rd_req),     32'(0));
      check("rst_wr_req",  32'(ifu_wr_req),     32'(0));
      check("rst_mem_op",  32'(pdp_mem_opcode), 32'(0));
      check("rst_op7",     32'(pdp_op7_opcode), 32'(0));
      check("rst_illegal", 32'(illegal_instr),  32'(0));
    end
  endtask

  // Runs one instruction from its FETCH cycle through the WAIT/HALTED tail.
  // abort_at >= 1 pulls reset_n low in that cycle after FETCH and stops.
  task automatic run_instr(input logic [11:0] pc, input bit first, input int nstall,
                           input int abort_at);
    exp_t e;
    int   nrd, nwr;
    e = model(pc);
    @(negedge clk);
    reset_n  = 1'b1;
    stall    = 1'b0;
    PC_value = first ? 12'($urandom) : pc;
    #1;
    check("fetch_rd_req",  32'(ifu_rd_req),  32'(1));
    check("fetch_rd_addr", 32'(ifu_rd_addr), 32'(pc));
    check("fetch_wr_req",  32'(ifu_wr_req),  32'(0));
    nrd = 0;
    nwr = 0;
    for (int n = 1; n <= e.lat; n++) begin
      @(negedge clk);
      PC_value = 12'($urandom);
      if (n == abort_at) reset_n = 1'b0;
      #1;
      check("rd_wr_excl", 32'(ifu_rd_req & ifu_wr_req), 32'(0));
      if (n == abort_at) begin
        check("abort_wr_req", 32'(ifu_wr_req), 32'(0));
        return;
      end
      if (ifu_rd_req) begin
        nrd++;
        check("ind_rd_addr", 32'(ifu_rd_addr), 32'(e.ea));
      end
      if (ifu_wr_req) begin
        nwr++;
        check("wr_addr", 32'(ifu_wr_addr), 32'(e.ea));
        check("wr_data", 32'(ifu_wr_data), 32'(e.wdata));
        mem[ifu_wr_addr] = ifu_wr_data;
      end
      if (n < e.lat) begin
        check("early_mem_op",  32'(pdp_mem_opcode), 32'(0));
        check("early_op7",     32'(pdp_op7_opcode), 32'(0));
        check("early_illegal", 32'(illegal_instr),  32'(0));
      end else begin
        check("issue_mem_op",  32'(pdp_mem_opcode), 32'(e.m));
        check("issue_op7",     32'(pdp_op7_opcode), 32'(e.o));
        check("issue_illegal", 32'(illegal_instr),  32'(e.ill));
      end
    end
    check("ind_rd_count", 32'(nrd), 32'(e.ind));
    check("wr_count",     32'(nwr), 32'(e.wr));
    if (e.halt) begin
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        PC_value = 12'($urandom);
        stall    = 1'($urandom);
        #1;
        check("halt_req",  32'(ifu_rd_req | ifu_wr_req), 32'(0));
        check("halt_ops",  32'({pdp_mem_opcode, pdp_op7_opcode, illegal_instr}), 32'(0));
      end
    end else begin
      for (int j = 0; j <= nstall; j++) begin
        @(negedge clk);
        stall    = (j < nstall);
        PC_value = 12'($urandom);
        #1;
        check("wait_req", 32'(ifu_rd_req | ifu_wr_req), 32'(0));
        check("wait_ops", 32'({pdp_mem_opcode, pdp_op7_opcode, illegal_instr}), 32'(0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] pc, w;
    int          kind;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);

    do_reset(3);
    check("base_addr", 32'(base_addr), 32'(12'o0200));

    // TAD direct, page zero
    mem[12'o0200] = 12'o1020;
    run_instr(12'o0200, 1'b1, 0, -1);

    // JMP current page, stall 4, then fetch from PC_value
    do_reset(2);
    mem[12'o0200] = 12'o5377;
    run_instr(12'o0200, 1'b1, 4, -1);
    mem[12'o0377] = 12'o7001;
    run_instr(12'o0377, 1'b0, 0, -1);

    // Auto-index indirect
    do_reset(2);
    mem[12'o0200] = 12'o0410;
    mem[12'o0010] = 12'o1234;
    run_instr(12'o0200, 1'b1, 0, -1);
    check("autoinc_mem", 32'(mem[12'o0010]), 32'(12'o1235));

    // Plain indirect, no write
    do_reset(2);
    mem[12'o0200] = 12'o1450;
    mem[12'o0050] = 12'o3000;
    run_instr(12'o0200, 1'b1, 1, -1);

    // Reset during IND_WR aborts the write; restart fetches START_ADDR
    do_reset(2);
    mem[12'o0200] = 12'o0410;
    mem[12'o0010] = 12'o1234;
    run_instr(12'o0200, 1'b1, 0, 4);
    check("abort_mem", 32'(mem[12'o0010]), 32'(12'o1234));
    run_instr(12'o0200, 1'b1, 0, -1);

    // IOT is illegal, then HLT
    do_reset(2);
    mem[12'o0200] = 12'o6001;
    mem[12'o0201] = 12'o7402;
    run_instr(12'o0200, 1'b1, 2, -1);
    run_instr(12'o0201, 1'b0, 0, -1);

    // Random instruction stream
    do_reset(1);
    pc = 12'o0200;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 5);
      w    = 12'($urandom);
      case (kind)
        0: begin w[11:9] = 3'($urandom_range(0, 5)); w[8] = 1'b0; end
        1: begin w[11:9] = 3'($urandom_range(0, 5)); w[8] = 1'b1; end
        2: w = {3'($urandom_range(0, 5)), 2'b10, 4'b0001, 3'($urandom)};
        3: begin
          w = op7_words[$urandom_range(0, 21)];
          if (w == 12'o7402) w = 12'o7000;
        end
        4: w = {3'o7, 9'($urandom)};
        default: w = {3'o6, 9'($urandom)};
      endcase
      mem[pc] = w;
      run_instr(pc, (t == 0), $urandom_range(0, 3), -1);
      pc = 12'($urandom_range(12'o0200, 12'o7777));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
